dct_zigzag_reader: RTL and testbench

- Drains the 64 16-bit coefficients of one finished 8x8 DCT block from the result RAM, in JPEG zig-zag order.
- Presents the coefficients as a valid/ready stream to the downstream entropy/quantiser stage.
- Is the read-side counterpart of the block loader: it is kicked by the DCT controller's done pulse and owns the RAM read port until the block is drained.

---
 rtl/dct_zigzag_reader.sv | 180 ++++++++++++++++++
 tb/tb_dct_zigzag_reader.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dct_zigzag_reader.sv
// dct_zigzag_reader
// Drains one finished 8x8 DCT block (64 coefficients) from the result RAM in
// JPEG zig-zag order and presents it as a valid/ready stream.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             one-cycle pulse, begins draining a block (ignored if busy)
//   row_order         (only with ZZ_ROW_ORDER_EN) 1 = plain row-major order
//   mem_rd_en         RAM read strobe
//   mem_addr          RAM address, row*8+col
//   mem_data          RAM read data, valid one cycle after mem_rd_en
//   out_data          coefficient at the head of the output buffer
//   out_index         zig-zag position 0..63 of out_data
//   out_last          high with index 63
//   out_valid/ready   stream handshake
//   busy              high while not idle
//   done              one-cycle pulse after the final beat is accepted
//
// Optional feature macro: ZZ_ROW_ORDER_EN (adds the row_order input).
module dct_zigzag_reader #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
`ifdef ZZ_ROW_ORDER_EN
    input  logic              row_order,
`endif
    output logic              mem_rd_en,
    output logic [5:0]        mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] out_data,
    output logic [5:0]        out_index,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 2);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t            state;
    logic [2:0]        row;
    logic [2:0]        col;
    logic [5:0]        issue_cnt;   // zig-zag index of the next read
    logic              rd_pending;  // read issued last cycle, data arrives now
    logic [5:0]        pend_idx;    // zig-zag index of that read
    logic              row_mode;

    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [5:0]        fifo_idx  [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  occupancy;

    logic              push;
    logic              pop;

    // Reads in flight are counted against the buffer so it can never overflow.
    assign occupancy = count + CNT_W'(rd_pending);
    assign mem_rd_en = (state == RUN) && (occupancy < CNT_W'(FIFO_DEPTH));
    assign busy      = (state != IDLE);

    assign push      = rd_pending;
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign out_data  = fifo_data[rd_ptr];
    assign out_index = fifo_idx[rd_ptr];
    assign out_last  = out_valid && (fifo_idx[rd_ptr] == 6'd63);

    assign mem_addr  = row_mode ? issue_cnt : {row, col};

    // Control FSM and zig-zag walk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            row        <= '0;
            col        <= '0;
            issue_cnt  <= '0;
            rd_pending <= 1'b0;
            pend_idx   <= '0;
            row_mode   <= 1'b0;
            done       <= 1'b0;
        end else begin
            done       <= 1'b0;
            rd_pending <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        row       <= '0;
                        col       <= '0;
                        issue_cnt <= '0;
`ifdef ZZ_ROW_ORDER_EN
                        row_mode  <= row_order;
`else
                        row_mode  <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    if (mem_rd_en) begin
                        rd_pending <= 1'b1;
                        pend_idx   <= issue_cnt;
                        // The walk stops at (7,7); advancing past it would wrap row.
                        if (issue_cnt == 6'd63) begin
                            state <= DRAIN;
                        end else begin
                            issue_cnt <= issue_cnt + 6'd1;
                            if ((row[0] ^ col[0]) == 1'b0) begin
                                if (col == 3'd7) begin
                                    row <= row + 3'd1;
                                end else if (row == 3'd0) begin
                                    col <= col + 3'd1;
                                end else begin
                                    row <= row - 3'd1;
                                    col <= col + 3'd1;
                                end
                            end else begin
                                if (row == 3'd7) begin
                                    col <= col + 3'd1;
                                end else if (col == 3'd0) begin
                                    row <= row + 3'd1;
                                end else begin
                                    row <= row + 3'd1;
                                    col <= col - 3'd1;
                                end
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (pop && out_last) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output buffer: written the cycle after each read, popped on handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_idx[i]  <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= mem_data;
                fifo_idx[wr_ptr]  <= pend_idx;
                wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dct_zigzag_reader.sv
// Self-checking bench for dct_zigzag_reader: table-driven full-throughput block,
// plus directed sequences for back-pressure, toggling ready, a stray start,
// mid-block reset and (with ZZ_ROW_ORDER_EN) row-major order.
module tb_dct_zigzag_reader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        mem_rd_en;
    logic [5:0]  mem_addr;
    logic [15:0] mem_data;
    logic [15:0] out_data;
    logic [5:0]  out_index;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
`ifdef ZZ_ROW_ORDER_EN
    logic        row_order;
`endif

    dct_zigzag_reader #(
        .DATA_W    (16),
        .FIFO_DEPTH(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
`ifdef ZZ_ROW_ORDER_EN
        .row_order(row_order),
`endif
        .mem_rd_en(mem_rd_en),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .out_data (out_data),
        .out_index(out_index),
        .out_last (out_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: mem[a] = {a, 4'b0}, one-cycle read latency
    always @(posedge clk) begin
        if (mem_rd_en) mem_data <= {6'b0, mem_addr, 4'b0};
    end

    // Standard JPEG zig-zag: natural (row-major) address of zig-zag index k
    int zz[64] = '{ 0,  1,  8, 16,  9,  2,  3, 10, 17, 24,
                   32, 25, 18, 11,  4,  5, 12, 19, 26, 33,
                   40, 48, 41, 34, 27, 20, 13,  6,  7, 14,
                   21, 28, 35, 42, 49, 56, 57, 50, 43, 36,
                   29, 22, 15, 23, 30, 37, 44, 51, 58, 59,
                   52, 45, 38, 31, 39, 46, 53, 60, 61, 54,
                   47, 55, 62, 63};

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int exp_addr(input int k, input bit rowm);
        return rowm ? k : zz[k];
    endfunction

    typedef struct {
        logic        start;
        logic        ready;
        logic        e_busy;
        logic        e_valid;
        logic        e_last;
        logic        e_done;
        logic        e_rd;
        logic [5:0]  e_addr;
        logic [15:0] e_data;
        logic [5:0]  e_index;
    } vec_t;

    vec_t vt[69];

    // Streams one block and checks order, data, stability under stall,
    // read addresses and the done pulse.
    // mode 0: ready=1; mode 1: ready low cycles 7..16; mode 2: ready 1,0,1,0...
    task automatic run_stream(input int mode, input bit extra_start, input bit rowm);
        int acc = 0, issued = 0, dones = 0, done_cyc = -1;
        bit prev_stall = 0, prev_last_acc = 0, start_next = 0, extra_used = 0;
        logic [15:0] hd = '0;
        logic [5:0]  hi = '0;
        logic        hl = 1'b0;
        bit finished = 0;
`ifdef ZZ_ROW_ORDER_EN
        row_order = rowm;
`endif
        @(posedge clk); #1;
        start = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        for (int cyc = 1; cyc < 400 && !finished; cyc++) begin
            @(posedge clk); #1;
            start = start_next;
            start_next = 0;
            case (mode)
                1:       out_ready = !(cyc >= 7 && cyc <= 16);
                2:       out_ready = (cyc % 2 == 1);
                default: out_ready = 1'b1;
            endcase
            @(negedge clk);
            chk("done_pulse", done, prev_last_acc);
            if (done) begin
                dones++;
                done_cyc = cyc;
            end
            if (mem_rd_en) begin
                chk("rd_addr", mem_addr, exp_addr(issued, rowm));
                issued++;
                chk("rd_count_le64", issued <= 64, 1);
            end
            if (mode == 1 && cyc >= 7 && cyc <= 16)
                chk("stall_rd_en", mem_rd_en, cyc < 9);
            if (mode == 1 && cyc == 16) begin
                chk("stall_data", out_data, 16'h0090);
                chk("stall_index", out_index, 4);
            end
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, hd);
                chk("hold_index", out_index, hi);
                chk("hold_last", out_last, hl);
            end
            prev_last_acc = 0;
            if (out_valid && out_ready) begin
                chk("beat_index", out_index, acc);
                chk("beat_data", out_data, exp_addr(acc, rowm) << 4);
                chk("beat_last", out_last, acc == 63);
                prev_last_acc = (acc == 63);
                acc++;
            end
            prev_stall = out_valid && !out_ready;
            hd = out_data;
            hi = out_index;
            hl = out_last;
            if (extra_start && !extra_used && out_valid && out_index == 6'd20) begin
                start_next = 1;
                extra_used = 1;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 2) begin
                chk("busy_after_done", busy, 0);
                finished = 1;
            end
        end
        if (!finished) begin
            miscompares++;
            $display("FAIL stream_timeout: got no done, expected done within 400 cycles");
        end
        chk("beats_accepted", acc, 64);
        chk("reads_issued", issued, 64);
        chk("done_count", dones, 1);
        start = 1'b0;
    endtask

    initial begin
        int c;
        bit hit;
        // Table for a full-throughput block; cycle c ends at clock edge c
        for (int i = 0; i < 69; i++) begin
            vt[i].start   = (i == 0);
            vt[i].ready   = 1'b1;
            vt[i].e_busy  = (i >= 1 && i <= 66);
            vt[i].e_valid = (i >= 3 && i <= 66);
            vt[i].e_last  = (i == 66);
            vt[i].e_done  = (i == 67);
            vt[i].e_rd    = (i >= 1 && i <= 64);
            vt[i].e_addr  = (i >= 1 && i <= 64) ? 6'(zz[i-1]) : 6'd0;
            vt[i].e_index = (i >= 3 && i <= 66) ? 6'(i - 3) : 6'd0;
            vt[i].e_data  = (i >= 3 && i <= 66) ? 16'(zz[i-3] << 4) : 16'd0;
        end

        rst_n = 1'b0;
        start = 1'b0;
        out_ready = 1'b0;
`ifdef ZZ_ROW_ORDER_EN
        row_order = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_data", out_data, 0);
        chk("rst_done", done, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 69; i++) begin
            @(posedge clk); #1;
            start = vt[i].start;
            out_ready = vt[i].ready;
            @(negedge clk);
            chk("t_busy", busy, vt[i].e_busy);
            chk("t_valid", out_valid, vt[i].e_valid);
            chk("t_done", done, vt[i].e_done);
            chk("t_rd_en", mem_rd_en, vt[i].e_rd);
            if (vt[i].e_rd) chk("t_addr", mem_addr, vt[i].e_addr);
            if (vt[i].e_valid) begin
                chk("t_data", out_data, vt[i].e_data);
                chk("t_index", out_index, vt[i].e_index);
                chk("t_last", out_last, vt[i].e_last);
            end
        end
        start = 1'b0;
        repeat (3) @(posedge clk);

        run_stream(1, 0, 0);   // back-pressure at beat 4
        run_stream(2, 0, 0);   // ready toggling
        run_stream(0, 1, 0);   // stray start at beat 20

        // Reset in the middle of a block
        @(posedge clk); #1;
        start = 1'b1;
        out_ready = 1'b1;
        hit = 0;
        c = 0;
        while (!hit && c < 100) begin
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            if (out_valid && out_index == 6'd30) hit = 1;
            c++;
        end
        chk("reached_beat30", hit, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("mid_rst_valid", out_valid, 0);
            chk("mid_rst_data", out_data, 0);
            chk("mid_rst_index", out_index, 0);
            chk("mid_rst_last", out_last, 0);
            chk("mid_rst_busy", busy, 0);
            chk("mid_rst_done", done, 0);
            chk("mid_rst_rd_en", mem_rd_en, 0);
            chk("mid_rst_addr", mem_addr, 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("post_rst_done", done, 0);
            chk("post_rst_busy", busy, 0);
            chk("post_rst_valid", out_valid, 0);
        end
        run_stream(0, 0, 0);   // fresh block restarts at index 0

`ifdef ZZ_ROW_ORDER_EN
        run_stream(0, 0, 1);
        run_stream(0, 0, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
